zxdma_ctrl: RTL and testbench

Sequencer for ZX-side DMA into NGS memory. It sits between the ZXBUS interface and the NGS memory arbiter. It synchronises the asynchronous ZX DMA strobes into cpu_clock, holds the ZX CPU in /WAIT while a memory slot is obtained, issues single-byte read or write requests to NGS memory, and returns read data to the bus. Address is formed from a configurable 16K page plus ZX A13..A0; completed transfers are counted for NGS firmware.

---
 rtl/zxdma_ctrl.sv | 156 +++++++++++++++
 tb/tb_zxdma_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zxdma_ctrl.sv
// ZX-side DMA sequencer: synchronises the ZX DMA strobes, holds ZX /WAIT while a
// single-byte NGS memory access is arbitrated, and counts completed transfers.

module zxdma_sync #(
  parameter int STAGES = 2
) (
  input  logic cpu_clock,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync_pipe;

  always_ff @(posedge cpu_clock or negedge rst_n) begin
    if (!rst_n) sync_pipe <= '0;
    else        sync_pipe <= {sync_pipe[STAGES-2:0], d};
  end

  assign q = sync_pipe[STAGES-1];
endmodule

module zxdma_ctrl #(
  parameter int PAGE_W = 5
) (
  input  logic                 cpu_clock,
  input  logic                 rst_n,
  input  logic                 dma_on,
  input  logic [PAGE_W-1:0]    dma_page,
  input  logic [13:0]          zxaddr,
  input  logic                 dmaread,
  input  logic                 dmawrite,
  input  logic [7:0]           dma_data_written,
  output logic [7:0]           dma_data_toberead,
  output logic                 wait_ena,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [PAGE_W+13:0]   mem_addr,
  output logic [7:0]           mem_wdata,
  input  logic [7:0]           mem_rdata,
  input  logic                 mem_ack,
  output logic                 dma_busy,
  output logic [15:0]          dma_count,
  input  logic                 count_clr
);
  localparam int NUM_STROBES = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_HOLD = 3'd2,
    WR_HOLD = 3'd3,
    WR_REQ  = 3'd4
  } state_t;

  state_t                 state;
  logic [NUM_STROBES-1:0] strobe_a;
  logic [NUM_STROBES-1:0] strobe_s;
  logic                   rd_s;
  logic                   wr_s;
  logic                   ack_ok;

  // Strobes are level-sensitive, so plain 2-flop synchronisers cannot lose a request.
  assign strobe_a = {dmawrite, dmaread};

  for (genvar i = 0; i < NUM_STROBES; i++) begin : g_sync
    zxdma_sync #(.STAGES(2)) u_sync (
      .cpu_clock (cpu_clock),
      .rst_n     (rst_n),
      .d         (strobe_a[i]),
      .q         (strobe_s[i])
    );
  end

  assign rd_s = strobe_s[0];
  assign wr_s = strobe_s[1];

  assign ack_ok   = mem_ack & ((state == RD_REQ) | (state == WR_REQ));
  assign wait_ena = dma_on & ((state == IDLE) | (state == RD_REQ) | (state == WR_REQ));

  always_ff @(posedge cpu_clock or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      mem_req           <= 1'b0;
      mem_we            <= 1'b0;
      mem_addr          <= '0;
      mem_wdata         <= '0;
      dma_data_toberead <= 8'h00;
      dma_busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dma_on && rd_s) begin
            mem_addr <= {dma_page, zxaddr};
            mem_we   <= 1'b0;
            mem_req  <= 1'b1;
            state    <= RD_REQ;
            dma_busy <= 1'b1;
          end else if (dma_on && wr_s) begin
            mem_addr <= {dma_page, zxaddr};
            mem_we   <= 1'b1;
            state    <= WR_HOLD;
            dma_busy <= 1'b1;
          end
        end
        RD_REQ: begin
          // A grant in the same cycle as dma_on falling still delivers its byte.
          if (mem_ack) begin
            dma_data_toberead <= mem_rdata;
            mem_req           <= 1'b0;
            state             <= dma_on ? RD_HOLD : IDLE;
            dma_busy          <= dma_on;
          end else if (!dma_on) begin
            mem_req  <= 1'b0;
            state    <= IDLE;
            dma_busy <= 1'b0;
          end
        end
        RD_HOLD: begin
          if (!rd_s || !dma_on) begin
            state    <= IDLE;
            dma_busy <= 1'b0;
          end
        end
        WR_HOLD: begin
          if (!dma_on) begin
            state    <= IDLE;
            dma_busy <= 1'b0;
          end else if (!wr_s) begin
            mem_wdata <= dma_data_written;
            mem_req   <= 1'b1;
            state     <= WR_REQ;
          end
        end
        WR_REQ: begin
          // Posted write always completes, even if dma_on has dropped.
          if (mem_ack) begin
            mem_req  <= 1'b0;
            state    <= IDLE;
            dma_busy <= 1'b0;
          end
        end
        default: begin
          mem_req  <= 1'b0;
          state    <= IDLE;
          dma_busy <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge cpu_clock or negedge rst_n) begin
    if (!rst_n)         dma_count <= '0;
    else if (count_clr) dma_count <= '0;
    else if (ack_ok)    dma_count <= dma_count + 16'd1;
  end
endmodule

// File: tb/tb_zxdma_ctrl.sv
// Scoreboard bench for zxdma_ctrl: bench acts as ZX bus and memory arbiter and
// checks every memory transfer, /WAIT timing, read data and the transfer count.

module tb_zxdma_ctrl;
  localparam int PAGE_W = 5;
  localparam int AW     = PAGE_W + 14;

  logic              cpu_clock = 1'b0;
  logic              rst_n = 1'b0;
  logic              dma_on = 1'b0;
  logic [PAGE_W-1:0] dma_page = '0;
  logic [13:0]       zxaddr = '0;
  logic              dmaread = 1'b0;
  logic              dmawrite = 1'b0;
  logic [7:0]        dma_data_written = '0;
  logic [7:0]        dma_data_toberead;
  logic              wait_ena;
  logic              mem_req;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata = '0;
  logic              mem_ack = 1'b0;
  logic              dma_busy;
  logic [15:0]       dma_count;
  logic              count_clr = 1'b0;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    wdata;
  } xfer_t;

  xfer_t sb[$];
  int    total = 0;
  int    bad = 0;

  int         ack_lat = 0;
  int         lat_cnt = 0;
  logic       ack_hold = 1'b0;
  logic       stray_ack = 1'b0;
  logic       rd_fix_en = 1'b0;
  logic [7:0] rd_fix = 8'h00;
  logic [7:0] last_rdata = 8'h00;
  logic [15:0] exp_cnt = '0;
  logic [15:0] cnt_nxt = '0;
  logic [15:0] preload_val = '0;
  logic        preload_en = 1'b0;

  zxdma_ctrl #(.PAGE_W(PAGE_W)) dut (
    .cpu_clock         (cpu_clock),
    .rst_n             (rst_n),
    .dma_on            (dma_on),
    .dma_page          (dma_page),
    .zxaddr            (zxaddr),
    .dmaread           (dmaread),
    .dmawrite          (dmawrite),
    .dma_data_written  (dma_data_written),
    .dma_data_toberead (dma_data_toberead),
    .wait_ena          (wait_ena),
    .mem_req           (mem_req),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_rdata         (mem_rdata),
    .mem_ack           (mem_ack),
    .dma_busy          (dma_busy),
    .dma_count         (dma_count),
    .count_clr         (count_clr)
  );

  always #5 cpu_clock = ~cpu_clock;

  // Memory arbiter: grants a pending request after ack_lat idle cycles.
  always @(posedge cpu_clock) begin
    #1;
    if (mem_req && !ack_hold && !mem_ack) begin
      if (lat_cnt >= ack_lat) begin
        mem_ack   = 1'b1;
        mem_rdata = rd_fix_en ? rd_fix : 8'($urandom);
        lat_cnt   = 0;
      end else begin
        lat_cnt++;
      end
    end else begin
      mem_ack = stray_ack;
      lat_cnt = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clock);
    #1;
  endtask

  // Every memory handshake must match the oldest ZX access issued; it also drives the count model.
  task automatic monitor();
    xfer_t e;
    forever begin
      @(negedge cpu_clock);
      if (!rst_n) begin
        cnt_nxt = '0;
      end else begin
        if (mem_req && mem_ack) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected: got transfer addr=%0h we=%0b want none", mem_addr, mem_we);
          end else begin
            e = sb.pop_front();
            check("sb_we", 32'(mem_we), 32'(e.we));
            check("sb_addr", 32'(mem_addr), 32'(e.addr));
            if (e.we) check("sb_wdata", 32'(mem_wdata), 32'(e.wdata));
            else      last_rdata = mem_rdata;
          end
        end
        if (preload_en)                cnt_nxt = preload_val;
        else if (count_clr)            cnt_nxt = '0;
        else if (mem_req && mem_ack)   cnt_nxt = exp_cnt + 16'd1;
        else                           cnt_nxt = exp_cnt;
      end
    end
  endtask

  task automatic cnt_model();
    forever begin
      @(posedge cpu_clock or negedge rst_n);
      if (!rst_n) exp_cnt = '0;
      else        exp_cnt = cnt_nxt;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (dma_busy && n < 60) begin
      tick();
      n++;
    end
    check("idle_reached", 32'(dma_busy), 32'd0);
  endtask

  task automatic rd_phase(input logic [PAGE_W-1:0] pg, input logic [13:0] a, output int n);
    xfer_t t;
    t.we = 1'b0; t.addr = {pg, a}; t.wdata = 8'h00;
    sb.push_back(t);
    dma_page = pg; zxaddr = a; dmaread = 1'b1;
    n = 0;
    do begin tick(); n++; end while (wait_ena && n < 80);
    check("rd_data", 32'(dma_data_toberead), 32'(last_rdata));
    check("rd_addr", 32'(mem_addr), 32'({pg, a}));
    check("rd_we", 32'(mem_we), 32'd0);
    check("rd_busy", 32'(dma_busy), 32'd1);
  endtask

  task automatic rd_finish();
    dmaread = 1'b0;
    wait_idle();
    check("rd_count", 32'(dma_count), 32'(exp_cnt));
  endtask

  task automatic wr_phase(input logic [PAGE_W-1:0] pg, input logic [13:0] a, input logic [7:0] d);
    xfer_t t;
    int n = 0;
    t.we = 1'b1; t.addr = {pg, a}; t.wdata = d;
    sb.push_back(t);
    dma_page = pg; zxaddr = a; dma_data_written = d; dmawrite = 1'b1;
    do begin tick(); n++; end while (wait_ena && n < 60);
    check("wr_hold_latency", 32'(n), 32'd3);
    check("wr_hold_busy", 32'(dma_busy), 32'd1);
    check("wr_hold_noreq", 32'(mem_req), 32'd0);
    dmawrite = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!mem_req && n < 60);
    check("wr_req_latency", 32'(n), 32'd3);
    check("wr_req_we", 32'(mem_we), 32'd1);
    check("wr_req_wdata", 32'(mem_wdata), 32'(d));
    check("wr_req_addr", 32'(mem_addr), 32'({pg, a}));
    check("wr_req_wait", 32'(wait_ena), 32'd1);
  endtask

  initial begin
    int n;
    logic seen;
    xfer_t t;

    fork
      monitor();
      cnt_model();
    join_none

    repeat (3) tick();
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_rdata", 32'(dma_data_toberead), 32'd0);
    check("rst_count", 32'(dma_count), 32'd0);
    check("rst_busy", 32'(dma_busy), 32'd0);
    check("rst_wait_off", 32'(wait_ena), 32'd0);
    dma_on = 1'b1;
    #1 check("rst_wait_on", 32'(wait_ena), 32'd1);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Directed read: page 3, A=1234, immediate grant, byte A5.
    rd_fix_en = 1'b1; rd_fix = 8'hA5; ack_lat = 0;
    rd_phase(5'h03, 14'h1234, n);
    check("dir_rd_latency", 32'(n), 32'd4);
    check("dir_rd_addr", 32'(mem_addr), 32'h0D234);
    check("dir_rd_byte", 32'(dma_data_toberead), 32'h0A5);
    rd_finish();
    check("dir_rd_count", 32'(dma_count), 32'd1);
    rd_fix_en = 1'b0;

    // Directed write: A=0000, byte 5A.
    wr_phase(5'h03, 14'h0000, 8'h5A);
    wait_idle();
    check("dir_wr_count", 32'(dma_count), 32'd2);

    // Read strobe arrives while a posted write waits 10 cycles for its grant.
    ack_lat = 10;
    wr_phase(5'h0A, 14'h2AAA, 8'hC3);
    t.we = 1'b0; t.addr = {5'h11, 14'h0155}; t.wdata = 8'h00;
    sb.push_back(t);
    dma_page = 5'h11; zxaddr = 14'h0155; dmaread = 1'b1;
    n = 0;
    do begin tick(); n++; end while (wait_ena && n < 80);
    check("b2b_wait_held", 32'(n), 32'd23);
    check("b2b_sb_drained", 32'(sb.size()), 32'd0);
    check("b2b_rd_data", 32'(dma_data_toberead), 32'(last_rdata));
    rd_finish();
    check("b2b_count", 32'(dma_count), 32'd4);
    ack_lat = 0;

    // dma_on dropped while the read request is still unanswered.
    ack_hold = 1'b1;
    dma_page = 5'h02; zxaddr = 14'h0777; dmaread = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!mem_req && n < 60);
    check("drop_req_up", 32'(mem_req), 32'd1);
    dma_on = 1'b0;
    tick();
    check("drop_req", 32'(mem_req), 32'd0);
    check("drop_wait", 32'(wait_ena), 32'd0);
    check("drop_busy", 32'(dma_busy), 32'd0);
    check("drop_count", 32'(dma_count), 32'd4);
    dmaread = 1'b0; ack_hold = 1'b0;
    repeat (4) tick();
    dma_on = 1'b1;
    tick();
    check("drop_stays_idle", 32'(dma_busy), 32'd0);

    // Stray grant while idle must not count or start anything.
    stray_ack = 1'b1;
    repeat (3) tick();
    stray_ack = 1'b0;
    repeat (2) tick();
    check("stray_count", 32'(dma_count), 32'd4);
    check("stray_busy", 32'(dma_busy), 32'd0);

    // Random mix of reads and writes with varying grant latency.
    for (int i = 0; i < 24; i++) begin
      logic [PAGE_W-1:0] pg;
      logic [13:0]       a;
      logic [7:0]        d;
      pg = PAGE_W'($urandom);
      a  = 14'($urandom);
      d  = 8'($urandom);
      ack_lat = int'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        rd_phase(pg, a, n);
        check("rnd_rd_latency", 32'(n), 32'(4 + ack_lat));
        rd_finish();
      end else begin
        wr_phase(pg, a, d);
        wait_idle();
        check("rnd_wr_count", 32'(dma_count), 32'(exp_cnt));
      end
    end
    ack_lat = 0;

    // Counter wrap: stand in for 65535 earlier transfers, then one more.
    preload_val = 16'hFFFF; preload_en = 1'b1;
    force dut.dma_count = 16'hFFFF;
    tick();
    preload_en = 1'b0;
    release dut.dma_count;
    tick();
    rd_phase(5'h07, 14'h3FFF, n);
    rd_finish();
    check("wrap_zero", 32'(dma_count), 32'd0);

    // Clear in the same cycle as a grant: clear wins.
    wr_phase(5'h01, 14'h0100, 8'h11);
    wait_idle();
    check("pre_clr_count", 32'(dma_count), 32'd1);
    wr_phase(5'h01, 14'h0101, 8'h22);
    count_clr = 1'b1;
    tick();
    count_clr = 1'b0;
    check("clr_wins", 32'(dma_count), 32'd0);
    check("clr_model", 32'(dma_count), 32'(exp_cnt));
    wait_idle();

    // Reset while a write request is outstanding.
    ack_hold = 1'b1;
    wr_phase(5'h1F, 14'h2222, 8'hEE);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", 32'(mem_req), 32'd0);
    check("mid_rst_we", 32'(mem_we), 32'd0);
    check("mid_rst_addr", 32'(mem_addr), 32'd0);
    check("mid_rst_wdata", 32'(mem_wdata), 32'd0);
    check("mid_rst_rdata", 32'(dma_data_toberead), 32'd0);
    check("mid_rst_count", 32'(dma_count), 32'd0);
    check("mid_rst_busy", 32'(dma_busy), 32'd0);
    check("mid_rst_wait", 32'(wait_ena), 32'd1);
    sb.delete();
    repeat (2) tick();
    rst_n = 1'b1; ack_hold = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mem_req) seen = 1'b1;
    end
    check("post_rst_no_req", 32'(seen), 32'd0);
    check("post_rst_busy", 32'(dma_busy), 32'd0);

    repeat (3) tick();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
